// File: rtl/cordic_req_arbiter.sv
// Round-robin front end that shares one fixed-latency hyperbolic CORDIC
// pipeline among NREQ requesters. A {valid, id, err} tag rides alongside
// the datapath so each result can be routed back to its owner.
module cordic_req_arbiter #(
  parameter int          NREQ      = 4,
  parameter int          IDW       = 2,
  parameter int          LAT       = 5,
  parameter int          MAX_OUT   = 2,
  parameter logic [20:0] THETA_MAX = 21'h3243F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [21*NREQ-1:0]   req_theta,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic [20:0]          rsp_cosh,
  output logic [20:0]          rsp_sinh,
  output logic [20:0]          dp_theta,
  input  logic [20:0]          dp_cosh,
  input  logic [20:0]          dp_sinh,
  output logic                 busy
);

  localparam int             CW    = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]  MAX_C = CW'(MAX_OUT);

  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt [NREQ];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] inc;
  logic [NREQ-1:0] dec;
  logic           found;
  logic [IDW-1:0] g;
  logic           hs;
  logic [20:0]    theta_g;
  logic           err_in;

  logic           tag_v   [LAT];
  logic [IDW-1:0] tag_id  [LAT];
  logic           tag_err [LAT];

  // Eligibility uses registered counters only; a slot freed this cycle is usable next cycle.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (cnt[i] < MAX_C);
    end
  end

  // Round-robin search from ptr, grant and range-checked issue to the datapath.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    g     = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        g     = idx[IDW-1:0];
      end
    end
    hs        = found && !rst;
    req_ready = hs ? (NREQ'(1) << g) : '0;
    theta_g   = req_theta[21*g +: 21];
    err_in    = (theta_g >= THETA_MAX);
    dp_theta  = (hs && !err_in) ? theta_g : '0;
  end

  // Per-requester credit events: issue increments, returning result decrements.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      inc[i] = hs && (g == IDW'(i));
      dec[i] = rsp_valid && (rsp_id == IDW'(i));
    end
  end

  // Round-robin pointer advances past the granted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (g == IDW'(NREQ - 1)) ? '0 : g + IDW'(1);
    end
  end

  // Outstanding-request counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (inc[i] && !dec[i])      cnt[i] <= cnt[i] + CW'(1);
        else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // Counter bounds: no overflow past MAX_OUT, no underflow below zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        assert (!(inc[i] && !dec[i] && cnt[i] == MAX_C))
          else $error("credit overflow on requester %0d", i);
        assert (!(dec[i] && !inc[i] && cnt[i] == '0))
          else $error("credit underflow on requester %0d", i);
      end
    end
  end

  // Tag pipe matching the datapath latency; id/err are zeroed on empty slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_v[s]   <= 1'b0;
        tag_id[s]  <= '0;
        tag_err[s] <= 1'b0;
      end
    end else begin
      tag_v[0]   <= hs;
      tag_id[0]  <= hs ? g : '0;
      tag_err[0] <= hs && err_in;
      for (int unsigned s = 1; s < LAT; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_id[s]  <= tag_id[s-1];
        tag_err[s] <= tag_err[s-1];
      end
    end
  end

  // Result routing and in-flight indication.
  always_comb begin
    rsp_valid = tag_v[LAT-1];
    rsp_id    = tag_id[LAT-1];
    rsp_err   = tag_err[LAT-1];
    rsp_cosh  = (rsp_valid && !rsp_err) ? dp_cosh : '0;
    rsp_sinh  = (rsp_valid && !rsp_err) ? dp_sinh : '0;
    busy      = 1'b0;
    for (int unsigned s = 0; s < LAT; s++) busy = busy | tag_v[s];
  end

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Scoreboard bench for cordic_req_arbiter with a stand-in fixed-latency datapath.
module tb_cordic_req_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [21*NREQ-1:0]  req_theta;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_err;
  logic [20:0]         rsp_cosh, rsp_sinh, dp_theta, dp_cosh, dp_sinh;
  logic                busy;

  cordic_req_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .LAT(LAT), .MAX_OUT(2), .THETA_MAX(21'h3243F)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_theta(req_theta),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_cosh(rsp_cosh), .rsp_sinh(rsp_sinh),
    .dp_theta(dp_theta), .dp_cosh(dp_cosh), .dp_sinh(dp_sinh), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: distinct, non-zero functions of theta after LAT cycles.
  function automatic logic [20:0] fcosh(input logic [20:0] t);
    return t ^ 21'h15555;
  endfunction
  function automatic logic [20:0] fsinh(input logic [20:0] t);
    return t + 21'h00123;
  endfunction

  logic [20:0] fs [LAT];
  always @(posedge clk) begin
    fs[0] <= dp_theta;
    for (int s = 1; s < LAT; s++) fs[s] <= fs[s-1];
  end
  assign dp_cosh = fcosh(fs[LAT-1]);
  assign dp_sinh = fsinh(fs[LAT-1]);

  typedef struct {
    logic [IDW-1:0] id;
    logic           err;
    logic [20:0]    cosh;
    logic [20:0]    sinh;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   issued[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_theta(input int i, input logic [20:0] v);
    req_theta[21*i +: 21] = v;
  endtask

  // One cycle: check grant, issued theta and busy; queue the expected response.
  task automatic step(input logic [NREQ-1:0] exp_ready);
    logic [20:0] th;
    logic        e;
    logic [20:0] exp_dp;
    logic        bexp;
    int          gi;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    exp_dp = '0;
    gi = 0;
    if (exp_ready != '0) begin
      for (int i = 0; i < NREQ; i++) if (exp_ready[i]) gi = i;
      th = req_theta[21*gi +: 21];
      e  = (th >= 21'h3243F);
      exp_dp = e ? 21'h0 : th;
      sb.push_back('{id: IDW'(gi), err: e, cosh: (e ? 21'h0 : fcosh(th)),
                     sinh: (e ? 21'h0 : fsinh(th)), due: cyc + LAT});
    end
    chk("dp_theta", 32'(dp_theta), 32'(exp_dp));
    bexp = 1'b0;
    foreach (issued[k]) if (issued[k] < cyc && cyc <= issued[k] + LAT) bexp = 1'b1;
    chk("busy", 32'(busy), 32'(bexp));
    if (exp_ready != '0) issued.push_back(cyc);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cosh", 32'(rsp_cosh), 32'(e.cosh));
          chk("rsp_sinh", 32'(rsp_sinh), 32'(e.sinh));
        end
      end else begin
        chk("idle_id_err", 32'({rsp_id, rsp_err}), 32'(0));
        chk("idle_data", 32'(rsp_cosh | rsp_sinh), 32'(0));
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("rsp_missing", 32'(rsp_valid), 32'(1));
          sb.delete(0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_theta = '0;
    #1;
    rst = 1'b1;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_dp_theta", 32'(dp_theta), 32'(0));
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request from requester 1, theta = 0.5
    set_theta(1, 21'h08000);
    req_valid = 4'b0010;
    step(4'b0010);
    req_valid = '0;
    repeat (7) step('0);

    // Round robin with all requesters valid; ptr is 2 after the previous grant
    for (int i = 0; i < NREQ; i++) set_theta(i, 21'(32'h01000 * (i + 1)));
    req_valid = '1;
    step(4'b0100); step(4'b1000); step(4'b0001); step(4'b0010);
    step(4'b0100); step(4'b1000); step(4'b0001); step(4'b0010);
    req_valid = '0;
    repeat (7) step('0);

    // Credit limit: requester 2 alone, two issues per six cycles
    set_theta(2, 21'h04000);
    req_valid = 4'b0100;
    step(4'b0100); step(4'b0100);
    repeat (4) step('0);
    step(4'b0100); step(4'b0100);
    repeat (4) step('0);
    step(4'b0100); step(4'b0100);
    req_valid = '0;
    repeat (7) step('0);

    // Range check at the bound, with bit 20 set, and just below the bound
    set_theta(0, 21'h3243F);
    req_valid = 4'b0001;
    step(4'b0001);
    set_theta(3, 21'h100000);
    req_valid = 4'b1000;
    step(4'b1000);
    set_theta(1, 21'h3243E);
    req_valid = 4'b0010;
    step(4'b0010);
    req_valid = '0;
    repeat (7) step('0);

    // Reset mid-flight: ptr is 2, requesters 0 and 3 compete
    set_theta(0, 21'h02000);
    set_theta(3, 21'h03000);
    req_valid = 4'b1001;
    step(4'b1000); step(4'b0001); step(4'b1000);
    req_valid = '0;
    step('0);
    #2;
    rst = 1'b1;
    req_valid = 4'b1001;
    sb.delete();
    issued.delete();
    #1;
    chk("midreset_ready", 32'(req_ready), 32'(0));
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("midreset_busy", 32'(busy), 32'(0));
    chk("midreset_dp_theta", 32'(dp_theta), 32'(0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    repeat (LAT + 1) step('0);
    req_valid = 4'b1001;
    step(4'b0001); step(4'b1000); step(4'b0001); step(4'b1000);
    req_valid = '0;
    repeat (7) step('0);

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
